// File: rtl/fixed_to_float_packer_pkg.sv
// Shared definitions for the fixed-to-float output stage and its rounding helper.
// Holds FSM encoding and IEEE-754 single-precision field constants.
package fixed_to_float_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ABS   = 2'd1,
        ST_NORM  = 2'd2,
        ST_ROUND = 2'd3
    } state_t;

    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fixed_to_float_packer_if.sv
// Operand/result bundle between the CORDIC core and the fixed-to-float packer.
// W is the fixed-point operand width (integer + fraction bits).
interface fixed_to_float_packer_if #(
    parameter int W = 32
) ();
    logic         start;
    logic [W-1:0] fx_in;
    logic [31:0]  fp_out;
    logic         busy;
    logic         done;

    modport master (
        output start,
        output fx_in,
        input  fp_out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  fx_in,
        output fp_out,
        output busy,
        output done
    );
endinterface

// File: rtl/fixed_to_float_packer_fp_round_rne.sv
// Round-to-nearest-even on a normalized mantissa, carrying into the exponent.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module fp_round_rne
    import fixed_to_float_packer_pkg::*;
(
    input  logic [MANT_W-1:0] i_mant,
    input  logic              i_guard,
    input  logic              i_sticky,
    input  logic [EXP_W:0]    i_exp,
    output logic [MANT_W-1:0] o_mant,
    output logic [EXP_W:0]    o_exp
);
    logic              w_up;
    logic              w_carry;
    logic [MANT_W-1:0] w_sum;

    // Exact ties round up only when the kept lsb is odd.
    assign w_up             = i_guard & (i_sticky | i_mant[0]);
    assign {w_carry, w_sum} = {1'b0, i_mant} + (MANT_W+1)'(w_up);

    // An all-ones mantissa wraps to zero and the exponent takes the carry.
    assign o_mant = w_sum;
    assign o_exp  = i_exp + (EXP_W+1)'(w_carry);
endmodule

// File: rtl/fixed_to_float_packer.sv
// Converts a signed fixed-point CORDIC result to an IEEE-754 single word.
// Latency: 2 edges for zero, 3 + leading-zero count otherwise; done pulses with fp_out.
// Backpressure: none; start is taken only while idle, starts while busy are dropped.
module fixed_to_float_packer
    import fixed_to_float_packer_pkg::*;
#(
    parameter int FLOAT_SIZE = 24,
    parameter int INT_SIZE   = 8,
    parameter int EXP_BIAS   = fixed_to_float_packer_pkg::EXP_BIAS
) (
    input  logic                    clk,
    input  logic                    rst,
    fixed_to_float_packer_if.slave  bus
);
    localparam int W = INT_SIZE + FLOAT_SIZE;
    localparam logic [EXP_W:0] EXP_INIT = (EXP_W+1)'(EXP_BIAS + INT_SIZE - 1);

    state_t            r_state;
    logic              r_sign;
    logic [W-1:0]      r_fx;
    logic [W-1:0]      r_mag;
    logic [EXP_W:0]    r_exp;
    logic [31:0]       r_fp;
    logic              r_done;
    logic              r_busy;

    logic [W-1:0]      w_abs;
    logic [MANT_W-1:0] w_mant;
    logic              w_guard;
    logic              w_sticky;
    logic [MANT_W-1:0] w_rmant;
    logic [EXP_W:0]    w_rexp;

    // Two's-complement negate; the most negative value maps to 2^(W-1) exactly.
    assign w_abs   = r_fx[W-1] ? (~r_fx + W'(1)) : r_fx;
    assign w_mant  = r_mag[W-2 -: MANT_W];
    assign w_guard = r_mag[W-25];

    generate
        if (W > 25) begin : g_sticky
            assign w_sticky = |r_mag[W-26:0];
        end else begin : g_no_sticky
            assign w_sticky = 1'b0;
        end
    endgenerate

    fp_round_rne u_round (
        .i_mant   (w_mant),
        .i_guard  (w_guard),
        .i_sticky (w_sticky),
        .i_exp    (r_exp),
        .o_mant   (w_rmant),
        .o_exp    (w_rexp)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_sign  <= 1'b0;
            r_fx    <= '0;
            r_mag   <= '0;
            r_exp   <= '0;
            r_fp    <= FP_ZERO;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_fx    <= bus.fx_in;
                        r_busy  <= 1'b1;
                        r_state <= ST_ABS;
                    end
                end
                ST_ABS: begin
                    r_sign  <= r_fx[W-1];
                    r_mag   <= w_abs;
                    r_exp   <= EXP_INIT;
                    r_state <= ST_NORM;
                end
                ST_NORM: begin
                    // A zero magnitude never normalizes; it resolves here to +0.
                    if (r_mag == '0) begin
                        r_fp    <= FP_ZERO;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (!r_mag[W-1]) begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - (EXP_W+1)'(1);
                    end else begin
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_fp    <= {r_sign, w_rexp[EXP_W-1:0], w_rmant};
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.fp_out = r_fp;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
endmodule

// File: tb/tb_fixed_to_float_packer.sv
// Directed-vector bench for fixed_to_float_packer at default parameters (Q8.24 in).
// Expected words and latencies are hand-computed from the conversion rules.
module tb_fixed_to_float_packer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    fixed_to_float_packer_if #(.W(32)) u_if ();

    fixed_to_float_packer #(
        .FLOAT_SIZE (24),
        .INT_SIZE   (8),
        .EXP_BIAS   (127)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launches a conversion from the current time; optionally pokes a stray start
    // with a different operand poke_at edges into the conversion.
    task automatic run_conv(input logic [31:0] fx, input logic [31:0] exp_fp,
                            input int exp_lat, input string tag, input int poke_at);
        int   lat;
        logic done_seen;
        logic busy_ok;
        u_if.start = 1'b1;
        u_if.fx_in = fx;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        u_if.fx_in = 32'hDEAD_BEEF;
        lat       = 0;
        done_seen = 1'b0;
        busy_ok   = 1'b1;
        while (lat < 100 && !done_seen) begin
            @(posedge clk);
            #1;
            lat++;
            if (u_if.done) begin
                done_seen = 1'b1;
            end else begin
                if (!u_if.busy) busy_ok = 1'b0;
                u_if.start = (lat == poke_at);
                u_if.fx_in = (lat == poke_at) ? 32'h8000_0000 : 32'hDEAD_BEEF;
            end
        end
        u_if.start = 1'b0;
        check({tag, "/done"},    32'(done_seen), 32'd1);
        check({tag, "/latency"}, 32'(lat),       32'(exp_lat));
        check({tag, "/fp_out"},  u_if.fp_out,    exp_fp);
        check({tag, "/busy_during"}, 32'(busy_ok), 32'd1);
        check({tag, "/busy_at_done"}, 32'(u_if.busy), 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b0;
        u_if.start = 1'b0;
        u_if.fx_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/fp_out", u_if.fp_out,       32'h0);
        check("reset/done",   32'(u_if.done),    32'd0);
        check("reset/busy",   32'(u_if.busy),    32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_conv(32'h0100_0000, 32'h3F80_0000, 10, "one",      -1);
        @(posedge clk);
        #1;
        check("one/done_pulse_width", 32'(u_if.done), 32'd0);
        check("one/fp_out_held",      u_if.fp_out,    32'h3F80_0000);

        run_conv(32'hFD80_0000, 32'hC020_0000,  9, "neg2p5",   -1);
        run_conv(32'h8000_0000, 32'hC300_0000,  3, "neg128",   -1);
        run_conv(32'h0000_0000, 32'h0000_0000,  2, "zero",     -1);
        run_conv(32'h0000_0001, 32'h3380_0000, 34, "lsb",      -1);
        run_conv(32'h7FFF_FFFF, 32'h4300_0000,  4, "carry",    -1);
        run_conv(32'h4000_0040, 32'h4280_0000,  4, "tie_even", -1);
        run_conv(32'h4000_0140, 32'h4280_0002,  4, "tie_even2", -1);
        run_conv(32'h4000_00C0, 32'h4280_0002,  4, "tie_odd",  -1);
        run_conv(32'h4000_0041, 32'h4280_0001,  4, "sticky",   -1);

        run_conv(32'h0100_0000, 32'h3F80_0000, 10, "start_busy", 3);
        @(posedge clk);
        #1;
        check("start_busy/not_queued", 32'(u_if.busy), 32'd0);

        run_conv(32'h0100_0000, 32'h3F80_0000, 10, "b2b_first",  -1);
        run_conv(32'hFD80_0000, 32'hC020_0000,  9, "b2b_second", -1);

        u_if.start = 1'b1;
        u_if.fx_in = 32'h0000_0001;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort/busy_before", 32'(u_if.busy), 32'd1);
        rst = 1'b0;
        #1;
        check("abort/fp_out", u_if.fp_out,    32'h0);
        check("abort/busy",   32'(u_if.busy), 32'd0);
        check("abort/done",   32'(u_if.done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort/done_held", 32'(u_if.done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abort/no_late_done", 32'(u_if.done), 32'd0);
        check("abort/idle",         32'(u_if.busy), 32'd0);
        run_conv(32'h0100_0000, 32'h3F80_0000, 10, "after_abort", -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
